// File: rtl/e203_exu_fpu_fcmp_wbck.sv
// FPU compare writeback stage.
// Applies RISC-V NaN rules to the raw eq/lt bits from FEQ/FLT/FLE, forms the
// integer result and fflags, and buffers results in a small FIFO ahead of
// the longpipe writeback arbiter.
// Optional macro E203_FPU_FCMP_BYPASS_EN: when the FIFO is empty and the
// writeback side is ready, the incoming result goes straight to the outputs
// in the same cycle and is not stored.
module e203_exu_fpu_fcmp_wbck #(
  parameter int DEPTH  = 2,
  parameter int ITAG_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [1:0]               i_op,
  input  logic [31:0]              i_rs1,
  input  logic [31:0]              i_rs2,
  input  logic                     i_eq,
  input  logic                     i_lt,
  input  logic [ITAG_W-1:0]        i_itag,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [31:0]              o_wbck_wdat,
  output logic [4:0]               o_fflags,
  output logic [ITAG_W-1:0]        o_itag,
  output logic [$clog2(DEPTH):0]   o_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic rs1_nan, rs2_nan, rs1_snan, rs2_snan, any_nan;
  logic res_bit, res_nv;

  // The sign bits play no part in NaN classification.
  logic unused_sign;
  assign unused_sign = i_rs1[31] ^ i_rs2[31];

  // Classify operands: NaN is all-ones exponent with nonzero mantissa;
  // signalling when the quiet bit (mantissa MSB) is clear.
  always_comb begin
    rs1_nan  = (i_rs1[30:23] == 8'hFF) && (i_rs1[22:0] != 23'd0);
    rs2_nan  = (i_rs2[30:23] == 8'hFF) && (i_rs2[22:0] != 23'd0);
    rs1_snan = rs1_nan && !i_rs1[22];
    rs2_snan = rs2_nan && !i_rs2[22];
    any_nan  = rs1_nan || rs2_nan;
  end

  // Result bit and invalid flag: FEQ is quiet (NV only on sNaN), FLT/FLE are
  // signalling (NV on any NaN), reserved opcode returns 0 with NV.
  always_comb begin
    res_bit = 1'b0;
    res_nv  = 1'b0;
    case (i_op)
      2'b00: begin
        res_bit = !any_nan && i_eq;
        res_nv  = rs1_snan || rs2_snan;
      end
      2'b01: begin
        res_bit = !any_nan && i_lt;
        res_nv  = any_nan;
      end
      2'b10: begin
        res_bit = !any_nan && (i_eq || i_lt);
        res_nv  = any_nan;
      end
      default: begin
        res_bit = 1'b0;
        res_nv  = 1'b1;
      end
    endcase
  end

  logic              bit_q [DEPTH];
  logic              nv_q  [DEPTH];
  logic [ITAG_W-1:0] tag_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fifo_full, fifo_empty, push, pop;
  logic              head_bit, head_nv;
  logic [ITAG_W-1:0] head_tag;

  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && o_ready;

`ifdef E203_FPU_FCMP_BYPASS_EN
  logic byp;
  assign byp      = fifo_empty && i_valid && o_ready;
  assign i_ready  = !fifo_full || byp;
  assign push     = i_valid && i_ready && !byp;
  assign o_valid  = !fifo_empty || byp;
  assign head_bit = byp ? res_bit : bit_q[rd_ptr_q];
  assign head_nv  = byp ? res_nv  : nv_q[rd_ptr_q];
  assign head_tag = byp ? i_itag  : tag_q[rd_ptr_q];
`else
  assign i_ready  = !fifo_full;
  assign push     = i_valid && i_ready;
  assign o_valid  = !fifo_empty;
  assign head_bit = bit_q[rd_ptr_q];
  assign head_nv  = nv_q[rd_ptr_q];
  assign head_tag = tag_q[rd_ptr_q];
`endif

  assign o_wbck_wdat = {31'd0, head_bit};
  assign o_fflags    = {head_nv, 4'b0000};
  assign o_itag      = head_tag;
  assign o_cnt       = cnt_q;

  // Next pointer/occupancy; flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; cleared on reset so the idle outputs read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bit_q[i] <= 1'b0;
        nv_q[i]  <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (push && !flush) begin
      bit_q[wr_ptr_q] <= res_bit;
      nv_q[wr_ptr_q]  <= res_nv;
      tag_q[wr_ptr_q] <= i_itag;
    end
  end

endmodule

// File: tb/tb_e203_exu_fpu_fcmp_wbck.sv
// Self-checking bench for e203_exu_fpu_fcmp_wbck: directed cases followed by
// randomized traffic checked against a queue-based reference model.
module tb_e203_exu_fpu_fcmp_wbck;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, i_valid, i_ready, i_eq, i_lt, o_valid, o_ready;
  logic [1:0]  i_op, i_itag, o_itag, o_cnt;
  logic [31:0] i_rs1, i_rs2, o_wbck_wdat;
  logic [4:0]  o_fflags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       b;
    logic       nv;
    logic [1:0] tag;
  } ent_t;

  ent_t q[$];

  e203_exu_fpu_fcmp_wbck #(.DEPTH(DEPTH), .ITAG_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_eq(i_eq), .i_lt(i_lt), .i_itag(i_itag),
    .o_valid(o_valid), .o_ready(o_ready), .o_wbck_wdat(o_wbck_wdat),
    .o_fflags(o_fflags), .o_itag(o_itag), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V compare semantics stated directly.
  function automatic ent_t model(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                 logic eq, logic lt, logic [1:0] tag);
    ent_t e;
    bit a_nan, b_nan, a_snan, b_snan, nan;
    a_nan  = (a[30:23] == 8'd255) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'd255) && (b[22:0] != 0);
    a_snan = a_nan && (a[22] == 1'b0);
    b_snan = b_nan && (b[22] == 1'b0);
    nan    = a_nan || b_nan;
    e.tag  = tag;
    if (op == 2'd0)      begin e.b = !nan && eq;         e.nv = a_snan || b_snan; end
    else if (op == 2'd1) begin e.b = !nan && lt;         e.nv = nan;              end
    else if (op == 2'd2) begin e.b = !nan && (eq || lt); e.nv = nan;              end
    else                 begin e.b = 1'b0;               e.nv = 1'b1;             end
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    bit   byp, exp_v, exp_rdy, push, pop, fl;
    ent_t cur, head;
    @(negedge clk);
    byp = 1'b0;
`ifdef E203_FPU_FCMP_BYPASS_EN
    byp = (q.size() == 0) && i_valid && o_ready;
`endif
    cur     = model(i_op, i_rs1, i_rs2, i_eq, i_lt, i_itag);
    exp_v   = (q.size() != 0) || byp;
    exp_rdy = (q.size() != DEPTH) || byp;
    chk("o_valid", {31'd0, o_valid}, {31'd0, exp_v});
    chk("i_ready", {31'd0, i_ready}, {31'd0, exp_rdy});
    chk("o_cnt", {30'd0, o_cnt}, 32'(q.size()));
    if (exp_v) begin
      head = byp ? cur : q[0];
      chk("o_wbck_wdat", o_wbck_wdat, {31'd0, head.b});
      chk("o_fflags", {27'd0, o_fflags}, {27'd0, head.nv, 4'b0000});
      chk("o_itag", {30'd0, o_itag}, {30'd0, head.tag});
    end
    push = i_valid && exp_rdy && !byp;
    pop  = (q.size() != 0) && o_ready;
    fl   = flush;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(cur);
    end
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic eq, logic lt, logic [1:0] tag);
    i_valid = v; i_op = op; i_rs1 = a; i_rs2 = b; i_eq = eq; i_lt = lt; i_itag = tag;
  endtask

  logic [31:0] pool [10];

  initial begin
    pool[0] = 32'h3F800000; pool[1] = 32'hBF800000; pool[2] = 32'h00000000;
    pool[3] = 32'h80000000; pool[4] = 32'h7FC00000; pool[5] = 32'h7F800001;
    pool[6] = 32'hFF800000; pool[7] = 32'h7FA00000; pool[8] = 32'hFFC00001;
    pool[9] = 32'h7F800000;

    rst = 1'b1; flush = 1'b0; o_ready = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_o_cnt", {30'd0, o_cnt}, 32'd0);
    chk("rst_wdat", o_wbck_wdat, 32'd0);
    chk("rst_fflags", {27'd0, o_fflags}, 32'd0);
    chk("rst_itag", {30'd0, o_itag}, 32'd0);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd1);
    cycle();

    // FEQ equal operands
    drive(1'b1, 2'd0, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 2'd1);
    cycle();
    i_valid = 1'b0;
    chk("feq_valid", {31'd0, o_valid}, 32'd1);
    chk("feq_wdat", o_wbck_wdat, 32'd1);
    chk("feq_fflags", {27'd0, o_fflags}, 32'd0);
    o_ready = 1'b1; cycle(); o_ready = 1'b0;

    // FLT with qNaN
    drive(1'b1, 2'd1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1, 2'd2);
    cycle();
    i_valid = 1'b0;
    chk("flt_qnan_wdat", o_wbck_wdat, 32'd0);
    chk("flt_qnan_fflags", {27'd0, o_fflags}, 32'h10);
    o_ready = 1'b1; cycle(); o_ready = 1'b0;

    // FEQ with sNaN, then with qNaN
    drive(1'b1, 2'd0, 32'h7F800001, 32'h00000000, 1'b0, 1'b0, 2'd3);
    cycle();
    drive(1'b1, 2'd0, 32'h7FC00000, 32'h00000000, 1'b0, 1'b0, 2'd0);
    cycle();
    i_valid = 1'b0;
    chk("feq_snan_wdat", o_wbck_wdat, 32'd0);
    chk("feq_snan_fflags", {27'd0, o_fflags}, 32'h10);
    o_ready = 1'b1; cycle();
    chk("feq_qnan_wdat", o_wbck_wdat, 32'd0);
    chk("feq_qnan_fflags", {27'd0, o_fflags}, 32'd0);
    cycle(); o_ready = 1'b0;

    // Fill with three FLE results while stalled
    drive(1'b1, 2'd2, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 2'd0);
    cycle();
    i_itag = 2'd1; cycle();
    i_itag = 2'd2;
    chk("full_i_ready", {31'd0, i_ready}, 32'd0);
    chk("full_o_cnt", {30'd0, o_cnt}, 32'd2);
    cycle();
    o_ready = 1'b1;
    chk("order_tag0", {30'd0, o_itag}, 32'd0);
    cycle();
    chk("order_tag1", {30'd0, o_itag}, 32'd1);
    chk("third_accept_rdy", {31'd0, i_ready}, 32'd1);
    cycle();
    i_valid = 1'b0;
    chk("order_tag2", {30'd0, o_itag}, 32'd2);
    cycle();
    o_ready = 1'b0;

    // Flush with concurrent push
    drive(1'b1, 2'd1, 32'hBF800000, 32'h3F800000, 1'b0, 1'b1, 2'd3);
    cycle(); cycle();
    flush = 1'b1; cycle();
    flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_cnt", {30'd0, o_cnt}, 32'd0);
    cycle();

    // Empty FIFO, writeback ready: latency depends on bypass build
    o_ready = 1'b1;
    drive(1'b1, 2'd2, 32'hBF800000, 32'h3F800000, 1'b0, 1'b1, 2'd1);
    #1;
`ifdef E203_FPU_FCMP_BYPASS_EN
    chk("byp_same_valid", {31'd0, o_valid}, 32'd1);
    chk("byp_same_wdat", o_wbck_wdat, 32'd1);
    cycle();
    i_valid = 1'b0;
    chk("byp_nothing_stored", {30'd0, o_cnt}, 32'd0);
`else
    chk("nobyp_same_valid", {31'd0, o_valid}, 32'd0);
    cycle();
    i_valid = 1'b0;
    chk("nobyp_next_valid", {31'd0, o_valid}, 32'd1);
    chk("nobyp_next_wdat", o_wbck_wdat, 32'd1);
`endif
    cycle(); cycle();

    // Reset mid-operation
    o_ready = 1'b0;
    drive(1'b1, 2'd3, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 2'd3);
    cycle(); cycle();
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    q.delete();
    chk("midrst_valid", {31'd0, o_valid}, 32'd0);
    chk("midrst_cnt", {30'd0, o_cnt}, 32'd0);
    chk("midrst_wdat", o_wbck_wdat, 32'd0);
    chk("midrst_fflags", {27'd0, o_fflags}, 32'd0);
    chk("midrst_itag", {30'd0, o_itag}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 9)],
            ($urandom_range(0, 4) == 0) ? $urandom : pool[$urandom_range(0, 9)],
            1'($urandom), 1'($urandom), 2'($urandom));
      o_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    flush = 1'b0; i_valid = 1'b0; o_ready = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
